// File: rtl/miter_pkg.sv
// Shared types and helpers for the sequential miter checker.
package miter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FAIL = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Width of a channel index; never zero so a single-channel miter still has a port bit.
  function automatic int unsigned chan_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/miter_lane_cmp.sv
// Masked gold/gate comparison for a single channel.
module miter_lane_cmp #(
  parameter int WIDTH = 1
) (
  input  logic             valid,
  input  logic             enable,
  input  logic [WIDTH-1:0] gold,
  input  logic [WIDTH-1:0] gate,
  input  logic [WIDTH-1:0] care,
  output logic             mismatch
);

  // Only cared-about bits of an enabled, valid sample can flag a difference.
  always_comb begin
    mismatch = valid & enable & (|((gold ^ gate) & care));
  end

endmodule

// File: rtl/miter_seq_checker.sv
// Sequential miter: compares gold/gate channel pairs sample by sample,
// counts samples and mismatching cycles, and records the first failure.
module miter_seq_checker
  import miter_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int WIDTH        = 1,
  parameter int CNT_W        = 16,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        in_valid,
  input  logic [CHANNELS*WIDTH-1:0]   gold,
  input  logic [CHANNELS*WIDTH-1:0]   gate,
  input  logic [CHANNELS*WIDTH-1:0]   care_mask,
  input  logic [CHANNELS-1:0]         ch_enable,
  output logic                        busy,
  output logic                        fail,
  output logic                        done,
  output logic [CHANNELS-1:0]         sticky_fail,
  output logic [CNT_W-1:0]            mismatch_cnt,
  output logic [CNT_W-1:0]            sample_cnt,
  output logic [chan_w(CHANNELS)-1:0] first_ch,
  output logic [WIDTH-1:0]            first_gold,
  output logic [WIDTH-1:0]            first_gate,
  output logic [CNT_W-1:0]            first_sample
);

  localparam int unsigned CH_W = chan_w(CHANNELS);

  state_e                state_q, state_d;
  logic [CHANNELS-1:0]   sticky_fail_q, sticky_fail_d;
  logic [CNT_W-1:0]      mismatch_cnt_q, mismatch_cnt_d;
  logic [CNT_W-1:0]      sample_cnt_q, sample_cnt_d;
  logic [CH_W-1:0]       first_ch_q, first_ch_d;
  logic [WIDTH-1:0]      first_gold_q, first_gold_d;
  logic [WIDTH-1:0]      first_gate_q, first_gate_d;
  logic [CNT_W-1:0]      first_sample_q, first_sample_d;

  logic [CHANNELS-1:0]   lane_mism;
  logic                  any_mism;
  logic [CH_W-1:0]       low_ch;
  logic [WIDTH-1:0]      low_gold;
  logic [WIDTH-1:0]      low_gate;

  genvar g;
  for (g = 0; g < CHANNELS; g++) begin : g_lane
    miter_lane_cmp #(
      .WIDTH(WIDTH)
    ) u_cmp (
      .valid   (in_valid),
      .enable  (ch_enable[g]),
      .gold    (gold[g*WIDTH +: WIDTH]),
      .gate    (gate[g*WIDTH +: WIDTH]),
      .care    (care_mask[g*WIDTH +: WIDTH]),
      .mismatch(lane_mism[g])
    );
  end

  // Lowest-index mismatching channel and its values (scanned high to low so the lowest wins).
  always_comb begin
    any_mism = |lane_mism;
    low_ch   = '0;
    low_gold = '0;
    low_gate = '0;
    for (int unsigned c = CHANNELS; c > 0; c--) begin
      if (lane_mism[c-1]) begin
        low_ch   = CH_W'(c - 1);
        low_gold = gold[(c-1)*WIDTH +: WIDTH];
        low_gate = gate[(c-1)*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and result-update logic; start overrides everything, including stop.
  always_comb begin
    state_d        = state_q;
    sticky_fail_d  = sticky_fail_q;
    mismatch_cnt_d = mismatch_cnt_q;
    sample_cnt_d   = sample_cnt_q;
    first_ch_d     = first_ch_q;
    first_gold_d   = first_gold_q;
    first_gate_d   = first_gate_q;
    first_sample_d = first_sample_q;
    if (start) begin
      state_d        = ST_RUN;
      sticky_fail_d  = '0;
      mismatch_cnt_d = '0;
      sample_cnt_d   = '0;
      first_ch_d     = '0;
      first_gold_d   = '0;
      first_gate_d   = '0;
      first_sample_d = '0;
    end else if (state_q == ST_RUN) begin
      if (in_valid && (sample_cnt_q != '1)) begin
        sample_cnt_d = sample_cnt_q + CNT_W'(1);
      end
      if (any_mism) begin
        if (mismatch_cnt_q != '1) begin
          mismatch_cnt_d = mismatch_cnt_q + CNT_W'(1);
        end
        sticky_fail_d = sticky_fail_q | lane_mism;
        // An empty sticky vector means no mismatch yet in this run.
        if (sticky_fail_q == '0) begin
          first_ch_d     = low_ch;
          first_gold_d   = low_gold;
          first_gate_d   = low_gate;
          first_sample_d = sample_cnt_q;
        end
      end
      if (any_mism && (STOP_ON_FAIL != 0)) begin
        state_d = ST_FAIL;
      end else if (stop) begin
        state_d = ST_DONE;
      end
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      sticky_fail_q  <= '0;
      mismatch_cnt_q <= '0;
      sample_cnt_q   <= '0;
      first_ch_q     <= '0;
      first_gold_q   <= '0;
      first_gate_q   <= '0;
      first_sample_q <= '0;
    end else begin
      state_q        <= state_d;
      sticky_fail_q  <= sticky_fail_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      sample_cnt_q   <= sample_cnt_d;
      first_ch_q     <= first_ch_d;
      first_gold_q   <= first_gold_d;
      first_gate_q   <= first_gate_d;
      first_sample_q <= first_sample_d;
    end
  end

  // Status decode; in keep-counting mode fail follows the sticky record instead of a state.
  always_comb begin
    busy         = (state_q == ST_RUN);
    done         = (state_q == ST_DONE);
    fail         = (state_q == ST_FAIL) || ((STOP_ON_FAIL == 0) && (sticky_fail_q != '0));
    sticky_fail  = sticky_fail_q;
    mismatch_cnt = mismatch_cnt_q;
    sample_cnt   = sample_cnt_q;
    first_ch     = first_ch_q;
    first_gold   = first_gold_q;
    first_gate   = first_gate_q;
    first_sample = first_sample_q;
  end

endmodule
